debouncer_v2_0: RTL and testbench

Parametrised multi-channel debouncer: each of `SignalWidth` inputs is synchronised, then filtered so that the output changes only after the synchronised input has held a new level for `DebounceCount` consecutive sample ticks. Sample ticks come from a shared internal prescaler. Each channel has registered one-cycle positive, negative and either-edge pulses, and each edge type can be enabled separately. The block sits between GPIO or switch inputs and UDB logic or interrupt sources. It replaces plain two-flop debouncing where contact bounce exceeds one sample period.

---
 rtl/debouncer_pkg.sv | 20 ++
 rtl/debouncer_channel.sv | 74 +++++++
 rtl/debouncer_v2_0.sv | 75 +++++++
 tb/tb_debouncer_v2_0.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debouncer_pkg.sv
// Shared limits and helpers for the multi-channel debouncer.
package debouncer_pkg;

    localparam int DEB_MAX_WIDTH = 32;
    localparam int DEB_MAX_COUNT = 255;
    localparam int DEB_MAX_DIV   = 65535;

    // Bits needed to hold 0..value-1, never fewer than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/debouncer_channel.sv
// One debounced channel: 2-flop synchroniser, stability counter, level
// register and registered edge pulses.
module debouncer_channel
    import debouncer_pkg::*;
#(
    parameter int   DebounceCount    = 4,
    parameter logic InitValue        = 1'b0,
    parameter bit   PosEdgeDetect    = 1'b1,
    parameter bit   NegEdgeDetect    = 1'b1,
    parameter bit   EitherEdgeDetect = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic tick,
    input  logic d,
    output logic q,
    output logic pos,
    output logic neg,
    output logic either
);

    localparam int              CntW    = clog2(DebounceCount);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCount - 1);

    logic            sync_p0;
    logic            sync_p1;
    logic [CntW-1:0] cnt;
    logic            upd;

    // Stage p0 -> p1: metastability chain, clocked every cycle regardless of tick
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= InitValue;
            sync_p1 <= InitValue;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    // The new level is accepted on the tick that completes the stable run
    assign upd = tick && (sync_p1 != q) && (cnt == CntLast);

    // Filter: count consecutive mismatching ticks, any agreeing tick restarts the run
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            q   <= InitValue;
        end else if (tick) begin
            if (sync_p1 == q) begin
                cnt <= '0;
            end else if (cnt == CntLast) begin
                q   <= sync_p1;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Edge pulses registered on the same edge as q so they line up with the new level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pos    <= 1'b0;
            neg    <= 1'b0;
            either <= 1'b0;
        end else begin
            pos    <= upd & sync_p1 & PosEdgeDetect;
            neg    <= upd & ~sync_p1 & NegEdgeDetect;
            either <= upd & EitherEdgeDetect;
        end
    end

endmodule

// File: rtl/debouncer_v2_0.sv
// Multi-channel debouncer top: shared sample-tick prescaler feeding
// independent per-channel filters.
module debouncer_v2_0
    import debouncer_pkg::*;
#(
    parameter int                   SignalWidth      = 1,
    parameter int                   DebounceCount    = 4,
    parameter int                   SampleDivider    = 1,
    parameter logic [SignalWidth-1:0] InitValue      = '0,
    parameter bit                   PosEdgeDetect    = 1'b1,
    parameter bit                   NegEdgeDetect    = 1'b1,
    parameter bit                   EitherEdgeDetect = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [SignalWidth-1:0] d,
    output logic [SignalWidth-1:0] q,
    output logic [SignalWidth-1:0] pos,
    output logic [SignalWidth-1:0] neg,
    output logic [SignalWidth-1:0] either
);

    logic tick;

    if (SignalWidth < 1 || SignalWidth > DEB_MAX_WIDTH) begin : g_bad_width
        $error("debouncer_v2_0: SignalWidth out of range");
    end
    if (DebounceCount < 1 || DebounceCount > DEB_MAX_COUNT) begin : g_bad_count
        $error("debouncer_v2_0: DebounceCount out of range");
    end
    if (SampleDivider < 1 || SampleDivider > DEB_MAX_DIV) begin : g_bad_div
        $error("debouncer_v2_0: SampleDivider out of range");
    end

    if (SampleDivider == 1) begin : g_no_div
        // Every clock is a sample tick
        assign tick = 1'b1;
    end else begin : g_div
        localparam logic [15:0] DivLast = 16'(SampleDivider - 1);
        logic [15:0] div_cnt;

        assign tick = (div_cnt == DivLast);

        // Prescaler: count 0..SampleDivider-1 and wrap
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                div_cnt <= '0;
            end else if (tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < SignalWidth; i++) begin : g_ch
        debouncer_channel #(
            .DebounceCount    (DebounceCount),
            .InitValue        (InitValue[i]),
            .PosEdgeDetect    (PosEdgeDetect),
            .NegEdgeDetect    (NegEdgeDetect),
            .EitherEdgeDetect (EitherEdgeDetect)
        ) u_channel (
            .clock   (clock),
            .reset_n (reset_n),
            .tick    (tick),
            .d       (d[i]),
            .q       (q[i]),
            .pos     (pos[i]),
            .neg     (neg[i]),
            .either  (either[i])
        );
    end

endmodule

// File: tb/tb_debouncer_v2_0.sv
// Bench for debouncer_v2_0: two instances (fast 8-channel, and prescaled
// 2-channel with pos/either disabled) checked against a behavioural model.
module tb_debouncer_v2_0;

    localparam int          A_DC   = 4;
    localparam logic [7:0]  A_INIT = 8'h01;
    localparam int          B_DC   = 3;
    localparam int          B_DIV  = 10;
    localparam logic [1:0]  B_INIT = 2'b01;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] dA, qA, posA, negA, eitherA;
    logic [1:0] dB, qB, posB, negB, eitherB;

    int checks = 0;
    int errors = 0;

    // model state
    logic [7:0] s1A, s2A, mqA, mposA, mnegA, meitA;
    logic [1:0] s1B, s2B, mqB, mposB, mnegB, meitB;
    int runA [8];
    int runB [2];
    int nB;
    int negB0_cnt;

    always #5 clock = ~clock;

    debouncer_v2_0 #(
        .SignalWidth(8), .DebounceCount(A_DC), .SampleDivider(1), .InitValue(A_INIT),
        .PosEdgeDetect(1'b1), .NegEdgeDetect(1'b1), .EitherEdgeDetect(1'b1)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .d(dA),
        .q(qA), .pos(posA), .neg(negA), .either(eitherA)
    );

    debouncer_v2_0 #(
        .SignalWidth(2), .DebounceCount(B_DC), .SampleDivider(B_DIV), .InitValue(B_INIT),
        .PosEdgeDetect(1'b0), .NegEdgeDetect(1'b1), .EitherEdgeDetect(1'b0)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .d(dB),
        .q(qB), .pos(posB), .neg(negB), .either(eitherB)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        s1A = A_INIT; s2A = A_INIT; mqA = A_INIT;
        mposA = '0; mnegA = '0; meitA = '0;
        s1B = B_INIT; s2B = B_INIT; mqB = B_INIT;
        mposB = '0; mnegB = '0; meitB = '0;
        for (int i = 0; i < 8; i++) runA[i] = 0;
        for (int i = 0; i < 2; i++) runB[i] = 0;
        nB = 0;
    endtask

    // Spec rule: q takes the synchronised level once it has disagreed with q
    // on DebounceCount consecutive sample ticks; s lags d by two clocks.
    task automatic model_edge();
        logic tickB;
        mposA = '0; mnegA = '0; meitA = '0;
        for (int i = 0; i < 8; i++) begin
            if (s2A[i] != mqA[i]) begin
                runA[i] = runA[i] + 1;
                if (runA[i] == A_DC) begin
                    mqA[i] = s2A[i];
                    runA[i] = 0;
                    meitA[i] = 1'b1;
                    if (s2A[i]) mposA[i] = 1'b1; else mnegA[i] = 1'b1;
                end
            end else begin
                runA[i] = 0;
            end
        end
        s2A = s1A; s1A = dA;

        tickB = ((nB % B_DIV) == B_DIV - 1);
        nB = nB + 1;
        mposB = '0; mnegB = '0; meitB = '0;
        for (int i = 0; i < 2; i++) begin
            if (tickB) begin
                if (s2B[i] != mqB[i]) begin
                    runB[i] = runB[i] + 1;
                    if (runB[i] == B_DC) begin
                        mqB[i] = s2B[i];
                        runB[i] = 0;
                        if (!s2B[i]) mnegB[i] = 1'b1;
                    end
                end else begin
                    runB[i] = 0;
                end
            end
        end
        s2B = s1B; s1B = dB;
    endtask

    task automatic check_all();
        chk("qA", 32'(qA), 32'(mqA));
        chk("posA", 32'(posA), 32'(mposA));
        chk("negA", 32'(negA), 32'(mnegA));
        chk("eitherA", 32'(eitherA), 32'(meitA));
        chk("qB", 32'(qB), 32'(mqB));
        chk("posB", 32'(posB), 32'(mposB));
        chk("negB", 32'(negB), 32'(mnegB));
        chk("eitherB", 32'(eitherB), 32'(meitB));
    endtask

    task automatic cyc();
        @(posedge clock);
        if (reset_n) model_edge();
        #1;
        if (negB[0]) negB0_cnt++;
        check_all();
    endtask

    initial begin
        int pulses;
        int n;
        bit found;
        reset_n = 1'b1;
        dA = '0;
        dB = '0;
        negB0_cnt = 0;
        #1 reset_n = 1'b0;
        model_reset();
        repeat (3) cyc();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("release_qA", 32'(qA), 32'(A_INIT));
        chk("release_eitherA", 32'(eitherA), 32'h0);

        // InitValue=1 with d=0 at release: q[0] falls after DebounceCount+2 clocks
        repeat (A_DC + 1) cyc();
        chk("init_hold_q0", 32'(qA[0]), 32'h1);
        cyc();
        chk("init_fall_q0", 32'(qA[0]), 32'h0);
        chk("init_fall_neg0", 32'(negA[0]), 32'h1);

        // Clean step
        dA = 8'h01;
        repeat (A_DC + 1) cyc();
        chk("step_q_early", 32'(qA), 32'h0);
        cyc();
        chk("step_q", 32'(qA), 32'h01);
        chk("step_pos", 32'(posA), 32'h01);
        cyc();
        chk("step_pos_gone", 32'(posA), 32'h0);

        // Bounce rejection
        dA = 8'h00;
        repeat (10) cyc();
        pulses = 0;
        foreach (dA[i]) begin end
        for (int i = 0; i < 9; i++) begin
            logic [8:0] pat;
            pat = 9'b111110101;
            dA = {7'b0, pat[i]};
            cyc();
            pulses += int'(posA[0]);
        end
        repeat (12) begin cyc(); pulses += int'(posA[0]); end
        chk("bounce_one_pulse", 32'(pulses), 32'd1);

        dA = 8'h00;
        repeat (10) cyc();
        pulses = 0;
        dA = 8'h01;
        repeat (3) begin cyc(); pulses += int'(qA[0]); end
        dA = 8'h00;
        repeat (12) begin cyc(); pulses += int'(qA[0]); end
        chk("short_pulse_rejected", 32'(pulses), 32'd0);

        // Simultaneous multi-channel change
        dA = 8'hA5;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cyc();
            if (posA != 8'h00) found = 1'b1;
        end
        chk("multi_rise_seen", 32'(found), 32'h1);
        chk("multi_rise_q", 32'(qA), 32'hA5);
        chk("multi_rise_pos", 32'(posA), 32'hA5);
        dA = 8'h5A;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cyc();
            if (eitherA != 8'h00) found = 1'b1;
        end
        chk("multi_swap_seen", 32'(found), 32'h1);
        chk("multi_swap_pos", 32'(posA), 32'h5A);
        chk("multi_swap_neg", 32'(negA), 32'hA5);
        chk("multi_swap_either", 32'(eitherA), 32'hFF);

        // Prescaled instance: reset-level fall on channel 0 already filtered
        chk("b_init_neg_pulses", 32'(negB0_cnt), 32'd1);

        // Prescaler latency on channel 1
        dB = 2'b10;
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            cyc();
            n++;
            if (qB[1]) found = 1'b1;
        end
        chk("presc_rise_seen", 32'(found), 32'h1);
        chk("presc_rise_in_time", 32'(n <= 2 + B_DC * B_DIV), 32'h1);

        dB = 2'b00;
        repeat (40) cyc();
        pulses = 0;
        dB = 2'b10;
        repeat (15) begin cyc(); pulses += int'(qB[1]); end
        dB = 2'b00;
        repeat (40) begin cyc(); pulses += int'(qB[1]); end
        chk("presc_glitch_rejected", 32'(pulses), 32'd0);

        // Reset mid-count acts without a clock edge
        dA = 8'hA5;
        dB = 2'b10;
        repeat (3) cyc();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_qA", 32'(qA), 32'(A_INIT));
        chk("async_rst_qB", 32'(qB), 32'(B_INIT));
        chk("async_rst_negA", 32'(negA), 32'h0);
        repeat (2) cyc();
        @(negedge clock);
        reset_n = 1'b1;

        // Randomised traffic against the model
        n = 0;
        while (n < 400) begin
            int hold;
            hold = $urandom_range(1, 8);
            dA = 8'($urandom);
            dB = 2'($urandom_range(0, 3));
            repeat (hold) begin cyc(); n++; end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
